// File: rtl/spike_synapse_decoder_pkg.sv
// Shared types and constants for spiking-synapse blocks.
package snn_pkg;
  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {IDLE, INTEGRATE, REFRACTORY} state_e;

  localparam logic signed [15:0] CUR_MAX = 16'sh7FFF;
  localparam logic signed [15:0] CUR_MIN = 16'sh8000;
endpackage

// File: rtl/spike_synapse_decoder_if.sv
// Spike-in / current-out bundle between a neuron model and its synapse decoder.
interface spike_synapse_decoder_if #(parameter int WIDTH = snn_pkg::WIDTH_DEF);
  logic             spike_in;
  logic             tick;
  logic [WIDTH-1:0] weight;
  logic [WIDTH-1:0] current_out;
  logic [WIDTH-1:0] spike_count;
  logic [WIDTH-1:0] isi;
  logic             isi_valid;
  logic [7:0]       dropped_count;
  logic             busy;

  modport master (output spike_in, tick, weight,
                  input  current_out, spike_count, isi, isi_valid, dropped_count, busy);
  modport slave  (input  spike_in, tick, weight,
                  output current_out, spike_count, isi, isi_valid, dropped_count, busy);
endinterface

// File: rtl/spike_synapse_decoder_decay_sat.sv
// Combinational next-current: optional exponential decay, then optional saturating weight add.
module synapse_decay_sat #(
  parameter int WIDTH       = 16,
  parameter int DECAY_SHIFT = 3
) (
  input  logic signed [WIDTH-1:0] cur_i,
  input  logic signed [WIDTH-1:0] weight_i,
  input  logic                    do_tick_i,
  input  logic                    do_add_i,
  output logic signed [WIDTH-1:0] nxt_o
);
  logic signed [WIDTH-1:0] d;
  logic signed [WIDTH-1:0] dec;
  logic signed [WIDTH:0]   sum;

  always_comb begin
    d = cur_i >>> DECAY_SHIFT;
    // small positives would stall above zero without the forced step of 1
    if (d == '0 && cur_i > 0) d = {{(WIDTH-1){1'b0}}, 1'b1};
    dec = do_tick_i ? cur_i - d : cur_i;
    sum = {dec[WIDTH-1], dec} + {weight_i[WIDTH-1], weight_i};
    nxt_o = dec;
    if (do_add_i) begin
      if (sum[WIDTH] != sum[WIDTH-1])
        nxt_o = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
        nxt_o = sum[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/spike_synapse_decoder.sv
// Turns a neuron spike level into a decaying signed synaptic current plus spike statistics.
module spike_synapse_decoder
  import snn_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int DECAY_SHIFT   = 3,
  parameter int REFRACT_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  spike_synapse_decoder_if.slave bus
);
  localparam logic [WIDTH-1:0] RT = WIDTH'(REFRACT_TICKS);

  state_e                  state_q;
  logic                    spike_q;
  logic signed [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0]        cnt_q, isi_q, tcnt_q, refr_q;
  logic                    isi_vld_q, first_q;
  logic [7:0]              drop_q;
  logic                    rise, accept, drop;

  assign rise   = bus.spike_in & ~spike_q;
  assign accept = rise && (state_q != REFRACTORY);
  assign drop   = rise && (state_q == REFRACTORY);

  synapse_decay_sat #(.WIDTH(WIDTH), .DECAY_SHIFT(DECAY_SHIFT)) u_dsat (
    .cur_i     (cur_q),
    .weight_i  (bus.weight),
    .do_tick_i (bus.tick),
    .do_add_i  (accept),
    .nxt_o     (cur_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      spike_q   <= 1'b0;
      cur_q     <= '0;
      cnt_q     <= '0;
      isi_q     <= '0;
      tcnt_q    <= '0;
      refr_q    <= '0;
      isi_vld_q <= 1'b0;
      first_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      spike_q   <= bus.spike_in;
      cur_q     <= cur_d;
      isi_vld_q <= 1'b0;

      // a tick coinciding with an accept is swallowed by the clear
      if (accept)                        tcnt_q <= '0;
      else if (bus.tick && tcnt_q != '1) tcnt_q <= tcnt_q + 1'b1;

      if (accept) begin
        first_q <= 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        if (first_q) begin
          isi_q     <= tcnt_q;
          isi_vld_q <= 1'b1;
        end
      end

      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;

      case (state_q)
        IDLE, INTEGRATE: begin
          if (accept) begin
            state_q <= (REFRACT_TICKS == 0) ? INTEGRATE : REFRACTORY;
            refr_q  <= RT;
          end else if (state_q == INTEGRATE && cur_d == '0) begin
            state_q <= IDLE;
          end
        end
        REFRACTORY: begin
          if (bus.tick) begin
            refr_q <= refr_q - 1'b1;
            if (refr_q <= 1) state_q <= INTEGRATE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.current_out   = cur_q;
  assign bus.spike_count   = cnt_q;
  assign bus.isi           = isi_q;
  assign bus.isi_valid     = isi_vld_q;
  assign bus.dropped_count = drop_q;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: doc/spike_synapse_decoder.md
Name: spike_synapse_decoder

Overview:
Receive side of the neuron spike interface: turns the spike level a neuron model emits back into a 16-bit signed synaptic current suitable for a downstream neuron's current_in.
- Each accepted spike adds a signed weight to the current.
- The current decays exponentially once per dt tick.
- Also reports accepted-spike count, inter-spike interval (ISI) in ticks, and spikes dropped during refractory.

Parameters:
- WIDTH, 16, width of current, weight, count and ISI datapaths
- DECAY_SHIFT, 3, decay per tick is current >>> DECAY_SHIFT (arithmetic shift)
- REFRACT_TICKS, 4, ticks after an accepted spike during which rising edges are ignored; 0 = no refractory

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- spike_in  in  1  spike level from neuron, high while membrane is at or above threshold; same clock domain
- tick  in  1  one-cycle strobe marking one dt step
- weight  in  WIDTH  signed synaptic weight, sampled on the accepting cycle
- current_out  out  WIDTH  signed synaptic current, registered
- spike_count  out  WIDTH  accepted spikes, saturating
- isi  out  WIDTH  ticks between last two accepted spikes
- isi_valid  out  1  one-cycle pulse when isi updates
- dropped_count  out  8  rising edges ignored in refractory, saturating
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; state IDLE; spike_q=0; tick counter 0; first_seen=0.
- Edge detect: spike_q registers spike_in. A rising edge is spike_in & ~spike_q. A held-high level counts once.
- Latency: an accepted edge in cycle N is visible on current_out, spike_count, isi and isi_valid after the clock edge ending cycle N.
- States:
  - IDLE: current_out == 0.
  - INTEGRATE: edges accepted; decay applied on each tick.
  - REFRACTORY: decay still applied on each tick; edges ignored.
- Transitions:
  - IDLE or INTEGRATE, on edge → REFRACTORY, with refract counter = REFRACT_TICKS. If REFRACT_TICKS == 0, go to INTEGRATE instead.
  - REFRACTORY, on tick → decrement the refract counter. When it reaches 0 → INTEGRATE.
  - INTEGRATE, with the next current_out == 0 and no edge → IDLE.
  - REFRACTORY never goes directly to IDLE.
- Decay on tick: d = cur >>> DECAY_SHIFT.
  - If d == 0 and cur > 0, then d = 1.
  - nxt = cur - d.
  - Negative values converge to 0 because -1 >>> s = -1.
- Spike accept: current = sat(decayed_or_held + weight).
  - Computed in WIDTH+1 bits and clamped to 0x7FFF / 0x8000.
  - Simultaneous tick and edge: decay first, then add.
- ISI:
  - A tick counter increments on each tick, saturating at 0xFFFF.
  - On an accepted edge the counter clears to 0. A tick in the same cycle is not counted.
  - The first accepted edge after reset sets first_seen and does not update isi or pulse isi_valid.
  - Later accepted edges: isi = counter value before the clear; isi_valid pulses for 1 cycle.
- spike_count increments on every accepted edge and holds at 0xFFFF.
- dropped_count increments on each edge seen in REFRACTORY and holds at 0xFF.
- Reset mid-operation: everything returns immediately to reset values. If spike_in is high at reset release, it produces an edge on the first cycle after release, because spike_q=0.
- weight == 0: the spike is still accepted (counts, ISI, refractory) with no current change.

Decomposition:
- Shared package `snn_pkg`:
  - state enum {IDLE, INTEGRATE, REFRACTORY}
  - CUR_MAX = 16'sh7FFF, CUR_MIN = 16'sh8000
  - default WIDTH
- One natural sub-module, `synapse_decay_sat`: purely combinational. Takes cur, weight, do_tick, do_add and DECAY_SHIFT, and returns the next current. Shared with future multi-synapse blocks.

Test Plan:
1. Reset then spike: weight=0x1000, edge → current_out=0x1000, spike_count=1, isi_valid stays 0. First tick → 0x0E00; second tick → 0x0C40.
2. Saturation: weight=0x7000, two accepted edges 5 ticks apart with REFRACT_TICKS=4 → current_out clamps at 0x7FFF. Second edge gives isi=5 with isi_valid high for 1 cycle.
3. Inhibitory and convergence:
   - weight=0xF000 (-4096): edge → 0xF000, tick → 0xF200.
   - From current_out=5, successive ticks → 4, 3, 2, 1, 0, then state IDLE and busy=0.
   - From -1, a tick → 0.
4. Refractory drop: edge, then a second edge 2 ticks later → ignored. dropped_count=1, spike_count=1, current_out unchanged except for decay.
5. Simultaneous tick and edge, from current_out=0x0800 with weight=0x0100 → result 0x0800, i.e. 0x0700+0x0100. ISI counter cleared to 0.
6. Held level and async reset:
   - spike_in high for 10 cycles → exactly 1 accept.
   - Assert reset mid-REFRACTORY, asynchronously between clock edges → all outputs read 0 immediately.
   - Release with spike_in high → one accept on the first post-release cycle.
